game_control: RTL
=================

# game_control

Turn-sequencing controller for the Chicken Cha-Cha-Cha board; it sits in front of `data_path` and drives it.
- Takes player button/switch input and issues the card-flip strobe (`A`) with the card face (`position_data`).
- Samples the match (`go`) and win (`W`) results, then drives the advance strobe (`B`) and the turn-advance pulse (`statecombo_next_turn`).
- Tracks which of the 12 cards are face-up this turn, and holds a miss display before passing the turn.

## Interface
- `MISS_HOLD`, default 25_000_000: cycles the miss result is held before the turn passes.
- `TURN_TIMEOUT`, default 250_000_000: idle cycles in `WAIT_FLIP` before forced turn end (only with `TURN_TIMEOUT_EN`).
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a game from `IDLE`.
- `num_players` in 2: player count minus 1; latched on `start`.
- `flip_req` in 1: one-cycle pulse, player flips card `card_sel`.
- `card_sel` in 4: card index 0..11; values 12..15 are ignored.
- `go` in 1: from data path; 1 = flipped face matches the tile ahead.
- `W` in 1: from data path; 1 = current player has won.
- `A` out 1: one-cycle flip strobe to the data path.
- `position_data` out 4: card face presented with `A`; held until the next flip.
- `B` out 1: one-cycle advance strobe, chicken moves one tile.
- `N` out 2: latched player count, to the data path.
- `statecombo_next_turn` out 1: one-cycle pulse, hand turn to next player.
- `face_up` out 12: card face-up mask for display.
- `miss` out 1: high while the miss is displayed.
- `game_over` out 1: high in `GAME_OVER`.

## Operation
- States:
  - `IDLE` → `WAIT_FLIP` on `start`.
  - `WAIT_FLIP` → `FLIP` on a valid `flip_req`.
  - `FLIP` → `SETTLE` → `CHECK`.
  - `CHECK` → `ADVANCE` if `go`=1, else `MISS`.
  - `ADVANCE` → `WIN_CHK` → `GAME_OVER` if `W`=1, else `WAIT_FLIP`.
  - `MISS` → `NEXT_TURN` when the hold counter expires.
  - `NEXT_TURN` → `WAIT_FLIP`.
  - `GAME_OVER` → `IDLE` on `start`; `start` only re-latches `num_players` in the `IDLE` cycle that follows.
- Valid flip: `flip_req`=1 in `WAIT_FLIP`, `card_sel`<12, and `face_up[card_sel]`=0. Every other flip is dropped with no side effect.
- `FLIP`:
  - `A`=1 and `position_data`=`card_sel` in the same cycle; `position_data` is registered on entry.
  - `face_up[card_sel]` is set.
- `SETTLE`: one cycle of margin for the data path's registered compare. `go` is sampled only in `CHECK`.
- `ADVANCE`: `B`=1 for one cycle. `W` is sampled in `WIN_CHK`, one cycle later.
- `MISS`: `miss`=1 while a down-counter loads `MISS_HOLD-1` on entry and counts to 0. Counter width is `$clog2(MISS_HOLD+1)`.
- `NEXT_TURN`: `statecombo_next_turn`=1 for one cycle and `face_up` clears to 0.
- `flip_req` is ignored outside `WAIT_FLIP`; no queuing.
- All 12 cards face-up after a match: the next entry to `WAIT_FLIP` immediately goes to `NEXT_TURN` (turn passes).

## Timing
- Reset values:
  - State = `IDLE`.
  - `A`, `B`, `statecombo_next_turn`, `miss`, `game_over` = 0.
  - `position_data` = 0, `N` = 0, `face_up` = 0, counters = 0.
- Reset mid-game aborts immediately; no pending strobe is emitted afterwards.
- Latencies, counted in `clk` rising edges:
  - `flip_req` edge to `A` high: 1 cycle.
  - `A` to `go` sample: 2 cycles.
  - Match: `go` sample to `B`: 1 cycle.
  - Miss: `go` sample to `statecombo_next_turn`: `MISS_HOLD`+1 cycles.
- Every strobe output is exactly one cycle wide and comes straight from a registered state decode.
- Outputs are registered or pure state decode; there is no combinational input-to-output path.
- `start` and `flip_req` in the same cycle: only the one legal in the current state acts.

## Configuration
- `TURN_TIMEOUT_EN` defined:
  - An idle counter runs in `WAIT_FLIP`. It resets on entry and on any valid flip.
  - Reaching `TURN_TIMEOUT` cycles forces `NEXT_TURN`.
- `TURN_TIMEOUT_EN` undefined: no timer logic; `WAIT_FLIP` waits indefinitely.

## Test plan
- Reset and start, `MISS_HOLD`=4:
  - Stimulus: `rst`=0 for 2 cycles, then `start`, `num_players`=2'd3.
  - Response: all outputs 0 during reset; `N`=3 one cycle after `start`; state `WAIT_FLIP`.
- Match then win:
  - Stimulus: flip card 5 with `go`=1, `W`=1 in `WIN_CHK`.
  - Response: `A` pulse with `position_data`=5, `B` pulse 3 cycles later, `game_over`=1 and no `statecombo_next_turn`.
- Miss:
  - Stimulus: flip card 2 with `go`=0.
  - Response: `miss`=1 for 4 cycles, one `statecombo_next_turn` pulse, `face_up` returns to 0.
- Illegal flips:
  - Stimulus: re-flip card 5 after a match, `card_sel`=13, and `flip_req` during `MISS`.
  - Response: no `A` pulse and `face_up` unchanged.
- Board exhaustion: 12 consecutive matches with `W`=0 → `face_up`=12'hFFF, then `statecombo_next_turn` pulse.
- Timeout, with `TURN_TIMEOUT_EN`, `TURN_TIMEOUT`=10: idle in `WAIT_FLIP` → `statecombo_next_turn` after 10 cycles; rebuilt without the macro, no pulse after 1000 cycles.

Source files
------------

// File: rtl/game_control.sv
// Turn sequencer for the Chicken Cha-Cha-Cha board: card flips, match/miss handling, turn passing.
// Optional build macro TURN_TIMEOUT_EN adds an idle timer that forces the turn to pass.
module game_control #(
  parameter int MISS_HOLD    = 25_000_000,
  parameter int TURN_TIMEOUT = 250_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  num_players,
  input  logic        flip_req,
  input  logic [3:0]  card_sel,
  input  logic        go,
  input  logic        W,
  output logic        A,
  output logic [3:0]  position_data,
  output logic        B,
  output logic [1:0]  N,
  output logic        statecombo_next_turn,
  output logic [11:0] face_up,
  output logic        miss,
  output logic        game_over
);

  localparam int MC_W = $clog2(MISS_HOLD + 1);

  typedef enum logic [3:0] {
    IDLE, WAIT_FLIP, FLIP, SETTLE, CHECK, ADVANCE, WIN_CHK, MISS, NEXT_TURN, GAME_OVER
  } state_t;

  state_t          state, state_nx;
  logic [MC_W-1:0] miss_cnt;
  logic            flip_ok, board_full, timeout;

  // card_sel >= 12 is rejected before the mask lookup matters
  assign flip_ok    = flip_req && (card_sel < 4'd12) && !face_up[card_sel];
  assign board_full = &face_up;

`ifdef TURN_TIMEOUT_EN
  localparam int TO_W = $clog2(TURN_TIMEOUT + 1);
  logic [TO_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                              idle_cnt <= '0;
    else if (state != WAIT_FLIP || flip_ok) idle_cnt <= '0;
    else                                   idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout = (idle_cnt == TO_W'(TURN_TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = |TURN_TIMEOUT;
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = WAIT_FLIP;
      WAIT_FLIP: begin
        if (board_full || timeout) state_nx = NEXT_TURN;
        else if (flip_ok)          state_nx = FLIP;
      end
      FLIP:      state_nx = SETTLE;
      SETTLE:    state_nx = CHECK;
      CHECK:     state_nx = go ? ADVANCE : MISS;
      ADVANCE:   state_nx = WIN_CHK;
      WIN_CHK:   state_nx = W ? GAME_OVER : WAIT_FLIP;
      MISS:      if (miss_cnt == '0) state_nx = NEXT_TURN;
      NEXT_TURN: state_nx = WAIT_FLIP;
      GAME_OVER: if (start) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // A new game starts with a clean board so leftover cards from the last game do not block flips
  always_ff @(posedge clk) begin
    if (!rst) begin
      position_data <= '0;
      N             <= '0;
      face_up       <= '0;
      miss_cnt      <= '0;
    end else begin
      if (state == IDLE && start) begin
        N       <= num_players;
        face_up <= '0;
      end
      if (state == WAIT_FLIP && state_nx == FLIP) begin
        position_data     <= card_sel;
        face_up[card_sel] <= 1'b1;
      end
      if (state_nx == NEXT_TURN) face_up <= '0;
      if (state == CHECK && !go)                 miss_cnt <= MC_W'(MISS_HOLD - 1);
      else if (state == MISS && miss_cnt != '0) miss_cnt <= miss_cnt - 1'b1;
    end
  end

  assign A                    = (state == FLIP);
  assign B                    = (state == ADVANCE);
  assign statecombo_next_turn = (state == NEXT_TURN);
  assign miss                 = (state == MISS);
  assign game_over            = (state == GAME_OVER);

endmodule
